// File: rtl/clint_ctrl.sv
// clint_ctrl: trap/interrupt sequencer driving the CSR int write port (async interrupts enabled by CLINT_ASYNC_INT_EN)
module clint_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ecall_i,
    input  logic              ebreak_i,
    input  logic              mret_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              ex_csr_we_i,
    input  logic [1:0]        int_flag_i,
    input  logic [DATA_W-1:0] csr_mtvec,
    input  logic [DATA_W-1:0] csr_mepc,
    input  logic [DATA_W-1:0] csr_mstatus,
    input  logic              global_int_en,
    output logic              csr_we,
    output logic [ADDR_W-1:0] csr_waddr,
    output logic [DATA_W-1:0] csr_wdata,
    output logic [ADDR_W-1:0] csr_raddr,
    output logic              hold_o,
    output logic              int_assert_o,
    output logic [ADDR_W-1:0] int_addr_o
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] W_MEPC    = 3'd1;
    localparam logic [2:0] W_MCAUSE  = 3'd2;
    localparam logic [2:0] W_MSTATUS = 3'd3;
    localparam logic [2:0] W_MRET    = 3'd4;
    localparam logic [2:0] ASSERT    = 3'd5;
    localparam logic [ADDR_W-1:0] A_MSTATUS = ADDR_W'(12'h300);
    localparam logic [ADDR_W-1:0] A_MEPC    = ADDR_W'(12'h341);
    localparam logic [ADDR_W-1:0] A_MCAUSE  = ADDR_W'(12'h342);
    localparam logic [DATA_W-1:0] C_ECALL   = DATA_W'(11);
    localparam logic [DATA_W-1:0] C_EBREAK  = DATA_W'(3);

    logic [2:0]        state;
    logic [DATA_W-1:0] cause;
    logic [ADDR_W-1:0] epc;
    logic              mret_q;
    logic              int_take;
    logic [DATA_W-1:0] int_cause;
    logic [ADDR_W-1:0] int_epc;
    logic              accept;
    logic [DATA_W-1:0] ms_trap;
    logic [DATA_W-1:0] ms_mret;

`ifdef CLINT_ASYNC_INT_EN
    localparam logic [DATA_W-1:0] C_EXT = {1'b1, (DATA_W-1)'(11)};
    localparam logic [DATA_W-1:0] C_TMR = {1'b1, (DATA_W-1)'(7)};
    assign int_take  = (int_flag_i != 2'b00) && global_int_en && !ex_csr_we_i;
    assign int_cause = int_flag_i[1] ? C_EXT : C_TMR;
    assign int_epc   = jump_flag_i ? jump_addr_i : inst_addr_i;
`else
    logic unused_async;
    assign unused_async = ^{int_flag_i, global_int_en, ex_csr_we_i, jump_flag_i, jump_addr_i};
    assign int_take  = 1'b0;
    assign int_cause = '0;
    assign int_epc   = inst_addr_i;
`endif

    assign accept = rst_n && (state == IDLE) && (ecall_i || ebreak_i || mret_i || int_take);

    // sequencer: latch cause/epc on detection, then step through the CSR writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cause  <= '0;
            epc    <= '0;
            mret_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ecall_i || ebreak_i) begin
                        state  <= W_MEPC;
                        cause  <= ecall_i ? C_ECALL : C_EBREAK;
                        epc    <= inst_addr_i;
                        mret_q <= 1'b0;
                    end else if (mret_i) begin
                        state  <= W_MRET;
                        mret_q <= 1'b1;
                    end else if (int_take) begin
                        state  <= W_MEPC;
                        cause  <= int_cause;
                        epc    <= int_epc;
                        mret_q <= 1'b0;
                    end
                end
                W_MEPC:    state <= W_MCAUSE;
                W_MCAUSE:  state <= W_MSTATUS;
                W_MSTATUS: state <= ASSERT;
                W_MRET:    state <= ASSERT;
                default:   state <= IDLE;
            endcase
        end
    end

    // mstatus images: trap stacks MIE into MPIE and clears MIE; mret restores MIE and sets MPIE
    always_comb begin
        ms_trap    = csr_mstatus;
        ms_trap[7] = csr_mstatus[3];
        ms_trap[3] = 1'b0;
        ms_mret    = csr_mstatus;
        ms_mret[3] = csr_mstatus[7];
        ms_mret[7] = 1'b1;
    end

    assign csr_raddr    = A_MSTATUS;
    assign hold_o       = (state != IDLE) || accept;
    assign csr_we       = state inside {W_MEPC, W_MCAUSE, W_MSTATUS, W_MRET};
    assign csr_waddr    = (state == W_MEPC)   ? A_MEPC :
                          (state == W_MCAUSE) ? A_MCAUSE :
                          (state == W_MSTATUS || state == W_MRET) ? A_MSTATUS : '0;
    assign csr_wdata    = (state == W_MEPC)    ? DATA_W'(epc) :
                          (state == W_MCAUSE)  ? cause :
                          (state == W_MSTATUS) ? ms_trap :
                          (state == W_MRET)    ? ms_mret : '0;
    assign int_assert_o = (state == ASSERT);
    assign int_addr_o   = !int_assert_o ? '0 : mret_q ? ADDR_W'(csr_mepc) : ADDR_W'(csr_mtvec);
endmodule
